// File: rtl/regfile_pkg.sv
// Shared constants and payload types for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W   = 19;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/regarb_fifo.sv
// DEPTH-entry synchronous FIFO of writeback requests; head is the oldest entry.
module regarb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head_c,
  output logic    full_c,
  output logic    empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_req_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port between two writeback sources,
// with a per-register pending-write scoreboard. Optional bypass: REGARB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] busy
);

  localparam int unsigned PEND_W = $clog2(DEPTH + 1);

  logic [PEND_W-1:0] a_pend [NUM_REGS];
  logic [PEND_W-1:0] b_pend [NUM_REGS];

  wb_req_t a_req, b_req, a_head, b_head;
  logic    a_full, a_empty, b_full, b_empty;
  logic    a_acc, b_acc, a_push, b_push, byp_a, byp_b;
  logic    grant_a, grant_b;
  logic    rf_cnt_a, rf_cnt_b;
  src_e    last_grant;

  // A register with a write pending from the other source is held off to keep write order.
  assign a_ready = !a_full && (b_pend[a_addr] == '0);
  assign b_ready = !b_full && (a_pend[b_addr] == '0) &&
                   !(a_valid && a_ready && (a_addr == b_addr) && (b_addr != '0));

  assign a_acc = a_valid && a_ready && (a_addr != '0);
  assign b_acc = b_valid && b_ready && (b_addr != '0);

`ifdef REGARB_BYPASS_EN
  assign byp_a = a_acc && a_empty && b_empty && !b_valid;
  assign byp_b = b_acc && a_empty && b_empty && !a_valid;
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  assign a_push = a_acc && !byp_a;
  assign b_push = b_acc && !byp_b;

  assign a_req = '{addr: a_addr, data: a_data};
  assign b_req = '{addr: b_addr, data: b_data};

  regarb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (a_push),
    .push_data(a_req),
    .pop      (grant_a),
    .head_c   (a_head),
    .full_c   (a_full),
    .empty_c  (a_empty)
  );

  regarb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (b_push),
    .push_data(b_req),
    .pop      (grant_b),
    .head_c   (b_head),
    .full_c   (b_full),
    .empty_c  (b_empty)
  );

  // Round-robin grant: on contention, favour the source not granted last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!a_empty && !b_empty) begin
      if (last_grant == SRC_B) grant_a = 1'b1;
      else                     grant_b = 1'b1;
    end else if (!a_empty) begin
      grant_a = 1'b1;
    end else if (!b_empty) begin
      grant_b = 1'b1;
    end
  end

  // Registered write port; rf_cnt_* mark writes that still hold a scoreboard count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      rf_cnt_a   <= 1'b0;
      rf_cnt_b   <= 1'b0;
      last_grant <= SRC_B;
    end else begin
      rf_we    <= 1'b0;
      rf_cnt_a <= 1'b0;
      rf_cnt_b <= 1'b0;
      if (grant_a) begin
        rf_we      <= 1'b1;
        rf_waddr   <= a_head.addr;
        rf_wdata   <= a_head.data;
        rf_cnt_a   <= 1'b1;
        last_grant <= SRC_A;
      end else if (grant_b) begin
        rf_we      <= 1'b1;
        rf_waddr   <= b_head.addr;
        rf_wdata   <= b_head.data;
        rf_cnt_b   <= 1'b1;
        last_grant <= SRC_B;
      end else if (byp_a) begin
        rf_we    <= 1'b1;
        rf_waddr <= a_addr;
        rf_wdata <= a_data;
      end else if (byp_b) begin
        rf_we    <= 1'b1;
        rf_waddr <= b_addr;
        rf_wdata <= b_data;
      end
    end
  end

  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] p,
                                                  input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return p + PEND_W'(1);
      2'b01:   return p - PEND_W'(1);
      default: return p;
    endcase
  endfunction

  // Counts drop when the write commits on the port, so busy covers the write cycle itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        a_pend[r] <= '0;
        b_pend[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        a_pend[r] <= pend_next(a_pend[r], a_push && (a_addr == ADDR_W'(r)),
                               rf_cnt_a && (rf_waddr == ADDR_W'(r)));
        b_pend[r] <= pend_next(b_pend[r], b_push && (b_addr == ADDR_W'(r)),
                               rf_cnt_b && (rf_waddr == ADDR_W'(r)));
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      busy[r] = (a_pend[r] | b_pend[r]) != '0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus, queued expected writes.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                a_valid, b_valid;
  logic                a_ready, b_ready;
  logic [ADDR_W-1:0]   a_addr, b_addr;
  logic [DATA_W-1:0]   a_data, b_data;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [NUM_REGS-1:0] busy;

  int n_checks = 0;
  int n_errors = 0;
  wb_req_t exp_q[$];

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_req_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: every write on the port must match the next queued expectation.
  always @(negedge clk) begin
    if (reset_n && rf_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got r%0d/%0h, required no write", rf_waddr, rf_wdata);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        check("wb_addr", 32'(rf_waddr), 32'(e.addr));
        check("wb_data", 32'(rf_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  logic [ADDR_W-1:0] t3_aa [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [ADDR_W-1:0] t3_ba [4] = '{3'd5, 3'd6, 3'd7, 3'd1};
  logic [DATA_W-1:0] t3_ad [4] = '{19'h0A001, 19'h0A002, 19'h0A003, 19'h0A004};
  logic [DATA_W-1:0] t3_bd [4] = '{19'h0B005, 19'h0B006, 19'h0B007, 19'h0B001};

  initial begin
    int  ai, bi;
    logic b_rdy_k2, a_rdy_k3;
    reset_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    #1 check("rst_rf_we", 32'(rf_we), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    reset_n = 1'b1;
    #1 check("rst_a_ready", 32'(a_ready), 32'(1));
    check("rst_b_ready", 32'(b_ready), 32'(1));

    // Reset mid-burst with three writes buffered.
    drive(1'b1, 3'd1, 19'h11111, 1'b1, 3'd5, 19'h55555);
    push_exp(3'd1, 19'h11111);
    #1 check("t1_ready_c0", 32'({a_ready, b_ready}), 32'(3));
    @(negedge clk);
    drive(1'b1, 3'd2, 19'h22222, 1'b1, 3'd6, 19'h66666);
    #1 check("t1_ready_c1", 32'({a_ready, b_ready}), 32'(3));
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #2 check("t1_busy_pre", 32'(busy), 32'(8'h66));
    reset_n = 1'b0;
    #1 check("t1_rst_rf_we", 32'(rf_we), 32'(0));
    check("t1_rst_busy", 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(5);
    check("t1_post_rf_we", 32'(rf_we), 32'(0));

`ifndef REGARB_BYPASS_EN
    // Single buffered write: rf_we two cycles after the request cycle.
    drive(1'b1, 3'd3, 19'h1ABCD, 1'b0, '0, '0);
    push_exp(3'd3, 19'h1ABCD);
    #1 check("t2_a_ready", 32'(a_ready), 32'(1));
    @(negedge clk);
    check("t2_busy_c1", 32'(busy), 32'(8'h08));
    check("t2_we_c1", 32'(rf_we), 32'(0));
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("t2_we_c2", 32'(rf_we), 32'(1));
    check("t2_busy_c2", 32'(busy), 32'(8'h08));
    @(negedge clk);
    check("t2_we_c3", 32'(rf_we), 32'(0));
    check("t2_busy_c3", 32'(busy), 32'(0));
`else
    // Bypassed write: rf_we the cycle after the request, scoreboard untouched.
    drive(1'b1, 3'd2, 19'h02222, 1'b0, '0, '0);
    push_exp(3'd2, 19'h02222);
    #1 check("t6_a_ready", 32'(a_ready), 32'(1));
    @(negedge clk);
    check("t6_we_c1", 32'(rf_we), 32'(1));
    check("t6_busy_c1", 32'(busy), 32'(0));
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("t6_we_c2", 32'(rf_we), 32'(0));
    check("t6_busy_c2", 32'(busy), 32'(0));
`endif
    idle(3);

    // Contention: grants alternate A,B starting with A after reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_exp(t3_aa[i], t3_ad[i]);
      push_exp(t3_ba[i], t3_bd[i]);
    end
    ai = 0; bi = 0;
    b_rdy_k2 = 1'b1; a_rdy_k3 = 1'b1;
    for (int k = 0; k < 40 && (ai < 4 || bi < 4); k++) begin
      drive(ai < 4, t3_aa[ai % 4], t3_ad[ai % 4], bi < 4, t3_ba[bi % 4], t3_bd[bi % 4]);
      #1;
      if (k == 2) b_rdy_k2 = b_ready;
      if (k == 3) a_rdy_k3 = a_ready;
      if (ai < 4 && a_ready) ai++;
      if (bi < 4 && b_ready) bi++;
      @(negedge clk);
    end
    check("t3_accepted", 32'(ai + bi), 32'(8));
    check("t3_b_full_k2", 32'(b_rdy_k2), 32'(0));
    check("t3_a_full_k3", 32'(a_rdy_k3), 32'(0));
    idle(8);

    // WAW: A to r5 held off until B's buffered r5 has been written.
    drive(1'b1, 3'd2, 19'h0C002, 1'b1, 3'd5, 19'h0D005);
    push_exp(3'd2, 19'h0C002);
    push_exp(3'd5, 19'h0D005);
    push_exp(3'd5, 19'h0C005);
    #1 check("t4_ready_c0", 32'({a_ready, b_ready}), 32'(3));
    @(negedge clk);
    drive(1'b1, 3'd5, 19'h0C005, 1'b0, '0, '0);
    #1 check("t4_a_ready_c1", 32'(a_ready), 32'(0));
    @(negedge clk);
    #1 check("t4_a_ready_c2", 32'(a_ready), 32'(0));
    @(negedge clk);
    #1 check("t4_a_ready_c3", 32'(a_ready), 32'(0));
    @(negedge clk);
    #1 check("t4_a_ready_c4", 32'(a_ready), 32'(1));
    @(negedge clk);
    idle(6);

    // Leave last grant on A so B wins the first contention below.
    do_reset();
    drive(1'b1, 3'd4, 19'h0E001, 1'b1, 3'd6, 19'h0E006);
    push_exp(3'd4, 19'h0E001);
    push_exp(3'd6, 19'h0E006);
    push_exp(3'd4, 19'h0E002);
    @(negedge clk);
    drive(1'b1, 3'd4, 19'h0E002, 1'b0, '0, '0);
    #1 check("t5p_a_ready", 32'(a_ready), 32'(1));
    @(negedge clk);
    idle(6);

    // Back-pressure: A buffer fills, addr 0 requests accepted but never written.
    drive(1'b1, 3'd1, 19'h0F001, 1'b1, 3'd5, 19'h0F005);
    push_exp(3'd5, 19'h0F005);
    push_exp(3'd1, 19'h0F001);
    push_exp(3'd6, 19'h0F006);
    push_exp(3'd2, 19'h0F002);
    push_exp(3'd3, 19'h0F003);
    #1 check("t5_ready_c0", 32'({a_ready, b_ready}), 32'(3));
    @(negedge clk);
    drive(1'b1, 3'd2, 19'h0F002, 1'b1, 3'd6, 19'h0F006);
    #1 check("t5_ready_c1", 32'({a_ready, b_ready}), 32'(3));
    @(negedge clk);
    drive(1'b1, 3'd3, 19'h0F003, 1'b1, 3'd0, 19'h7FFFF);
    #1 check("t5_a_full_c2", 32'(a_ready), 32'(0));
    check("t5_b_addr0_c2", 32'(b_ready), 32'(1));
    @(negedge clk);
    #1 check("t5_ready_c3", 32'({a_ready, b_ready}), 32'(3));
    check("t5_busy_c3", 32'(busy), 32'(8'h46));
    @(negedge clk);
    idle(8);

    check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
